// File: rtl/scan_pkg.sv
// ============================================================================
// Module  : scan_pkg
// Purpose : Shared types and constants for the decoder scan controller.
//           Holds the FSM state encoding and the select-index width.
// Ports   : (package - none)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package scan_pkg;

    // Width of the decoder select index (2-to-4 decoder).
    localparam int SEL_W = 2;

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ON    = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

endpackage : scan_pkg

`default_nettype wire

// File: rtl/scan_next_sel.sv
// ============================================================================
// Module  : scan_next_sel
// Purpose : Combinational round-robin picker. Returns the lowest enabled index
//           strictly above cur; if none exists, the lowest enabled index
//           overall and flags it as a wrap.
// Ports   : cur  [1:0] in  - current index
//           mask [3:0] in  - enabled indices
//           nxt  [1:0] out - chosen index (valid when any=1)
//           wrap       out - chosen index came from wrapping round
//           any        out - at least one index is enabled
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_next_sel
    import scan_pkg::*;
(
    input  logic [SEL_W-1:0] cur,
    input  logic [3:0]       mask,
    output logic [SEL_W-1:0] nxt,
    output logic             wrap,
    output logic             any
);

    logic [SEL_W-1:0] w_hi;
    logic [SEL_W-1:0] w_lo;
    logic             w_found;

    // Scanning from the top down lets the lowest qualifying bit win in both
    // the "above cur" search and the "lowest overall" search.
    always_comb begin
        w_hi    = '0;
        w_lo    = '0;
        w_found = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) begin
                w_lo = SEL_W'(i);
                if (i > int'(cur)) begin
                    w_hi    = SEL_W'(i);
                    w_found = 1'b1;
                end
            end
        end
    end

    assign any  = |mask;
    assign wrap = any & ~w_found;
    assign nxt  = w_found ? w_hi : w_lo;

endmodule : scan_next_sel

`default_nettype wire

// File: rtl/decoder_scan_ctrl.sv
// ============================================================================
// Module  : decoder_scan_ctrl
// Purpose : Round-robin scan controller driving a 2-to-4 enable decoder.
//           Each enabled index is held for ON_TICKS cycles with en high,
//           followed by BLANK_TICKS cycles of en low before the next index.
// Ports   : clk              in  - clock, rising edge
//           rst_n            in  - asynchronous active-low reset
//           run              in  - 1 = scan, 0 = stop
//           mask       [3:0] in  - bit i enables index i
//           sel        [1:0] out - decoder select (registered)
//           en               out - decoder enable (registered)
//           frame_done       out - one-cycle pulse on wrap to first index
//           busy             out - high while not idle
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_scan_ctrl
    import scan_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int ON_TICKS    = 1000,
    parameter int BLANK_TICKS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [3:0]       mask,
    output logic [SEL_W-1:0] sel,
    output logic             en,
    output logic             frame_done,
    output logic             busy
);

    // Reload values are the tick counts minus one: the counter expires on 0.
    localparam logic [CNT_W-1:0] C_ON_LOAD    = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] C_BLANK_LOAD = CNT_W'(BLANK_TICKS - 1);

    if ((ON_TICKS < 1) || (longint'(ON_TICKS) > (longint'(1) << CNT_W)) ||
        (BLANK_TICKS < 0) || (longint'(BLANK_TICKS) > (longint'(1) << CNT_W)))
    begin : g_bad_params
        $error("decoder_scan_ctrl: ON_TICKS/BLANK_TICKS out of range for CNT_W");
    end

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic [SEL_W-1:0] w_cur;
    logic [SEL_W-1:0] w_nxt;
    logic             w_wrap;
    logic             w_any;
    logic             w_done;

    // From IDLE the picker is fed the top index so that it wraps and returns
    // the lowest enabled bit; the wrap flag is ignored on that path.
    assign w_cur  = (r_state == ST_IDLE) ? {SEL_W{1'b1}} : sel;
    assign w_done = (r_cnt == '0);

    scan_next_sel u_next_sel (
        .cur  (w_cur),
        .mask (mask),
        .nxt  (w_nxt),
        .wrap (w_wrap),
        .any  (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            sel        <= '0;
            en         <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    en   <= 1'b0;
                    busy <= 1'b0;
                    if (run && w_any) begin
                        r_state <= ST_ON;
                        sel     <= w_nxt;
                        en      <= 1'b1;
                        busy    <= 1'b1;
                        r_cnt   <= C_ON_LOAD;
                    end
                end

                ST_ON, ST_BLANK: begin
                    if (!run) begin
                        // Abort: sel deliberately keeps its last value.
                        r_state <= ST_IDLE;
                        en      <= 1'b0;
                        busy    <= 1'b0;
                        r_cnt   <= '0;
                    end else if (!w_done) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if ((r_state == ST_ON) && (BLANK_TICKS > 0)) begin
                        r_state <= ST_BLANK;
                        en      <= 1'b0;
                        r_cnt   <= C_BLANK_LOAD;
                    end else if (!w_any) begin
                        // Select step with an empty mask ends the scan quietly.
                        r_state <= ST_IDLE;
                        en      <= 1'b0;
                        busy    <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_state    <= ST_ON;
                        sel        <= w_nxt;
                        en         <= 1'b1;
                        r_cnt      <= C_ON_LOAD;
                        frame_done <= w_wrap;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    en      <= 1'b0;
                    busy    <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule : decoder_scan_ctrl

`default_nettype wire

// File: tb/tb_decoder_scan_ctrl.sv
// ============================================================================
// Module  : tb_decoder_scan_ctrl
// Purpose : Self-checking bench for decoder_scan_ctrl. Two instances share
//           stimulus: A with a blanking gap, B with none. Both are compared
//           every cycle against a dwell-time reference model; a segment table
//           and hand-written sequences cover the specific scenarios.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoder_scan_ctrl;

    localparam int ON   = 4;
    localparam int BL_A = 2;
    localparam int BL_B = 0;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [3:0] mask;

    logic [1:0] sel_a, sel_b;
    logic       en_a, en_b, fd_a, fd_b, busy_a, busy_b;

    int n_chk  = 0;
    int n_fail = 0;

    decoder_scan_ctrl #(.CNT_W(8), .ON_TICKS(ON), .BLANK_TICKS(BL_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .run(run), .mask(mask),
        .sel(sel_a), .en(en_a), .frame_done(fd_a), .busy(busy_a)
    );

    decoder_scan_ctrl #(.CNT_W(8), .ON_TICKS(ON), .BLANK_TICKS(BL_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .run(run), .mask(mask),
        .sel(sel_b), .en(en_b), .frame_done(fd_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Tracks whether a scan is active, which index is shown, whether it is in
    // its lit or dark part, and how many cycles of that part remain.
    typedef struct {
        bit active;
        bit lit;
        int idx;
        int left;
        bit fd;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.active = 0; m.lit = 0; m.idx = 0; m.left = 0; m.fd = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int blank, bit r, logic [3:0] mk);
        mdl_t n = m;
        n.fd = 0;
        if (!m.active) begin
            if (r && mk != 4'd0) begin
                n.active = 1; n.lit = 1; n.left = ON;
                for (int k = 3; k >= 0; k--) if (mk[k]) n.idx = k;
            end
            return n;
        end
        if (!r) begin
            n.active = 0; n.lit = 0; n.left = 0;
            return n;
        end
        n.left = m.left - 1;
        if (n.left > 0) return n;
        if (m.lit && blank > 0) begin
            n.lit = 0; n.left = blank;
            return n;
        end
        if (mk == 4'd0) begin
            n.active = 0; n.lit = 0;
            return n;
        end
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m.idx + k) % 4;
            if (mk[c]) begin
                n.idx = c;
                n.fd  = (c <= m.idx);
                break;
            end
        end
        n.lit = 1; n.left = ON;
        return n;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic check_models();
        chk("A.sel",  32'(sel_a),  32'(ma.idx));
        chk("A.en",   32'(en_a),   32'(ma.active && ma.lit));
        chk("A.fd",   32'(fd_a),   32'(ma.fd));
        chk("A.busy", 32'(busy_a), 32'(ma.active));
        chk("B.sel",  32'(sel_b),  32'(mb.idx));
        chk("B.en",   32'(en_b),   32'(mb.active && mb.lit));
        chk("B.fd",   32'(fd_b),   32'(mb.fd));
        chk("B.busy", 32'(busy_b), 32'(mb.active));
    endtask

    // One clock: advance models with the inputs present at the edge, then
    // sample the DUT 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            ma = mdl_step(ma, BL_A, run, mask);
            mb = mdl_step(mb, BL_B, run, mask);
        end else begin
            ma = mdl_reset();
            mb = mdl_reset();
        end
        #1;
        check_models();
    endtask

    // Segment table for a full mask=1111 frame on instance A.
    typedef struct {
        logic [1:0] sel;
        logic       en;
        logic       fd_first;
        int         n;
    } seg_t;

    seg_t segs[10];

    initial begin
        bit ok;

        segs[0] = '{2'd0, 1'b1, 1'b0, 4};
        segs[1] = '{2'd0, 1'b0, 1'b0, 2};
        segs[2] = '{2'd1, 1'b1, 1'b0, 4};
        segs[3] = '{2'd1, 1'b0, 1'b0, 2};
        segs[4] = '{2'd2, 1'b1, 1'b0, 4};
        segs[5] = '{2'd2, 1'b0, 1'b0, 2};
        segs[6] = '{2'd3, 1'b1, 1'b0, 4};
        segs[7] = '{2'd3, 1'b0, 1'b0, 2};
        segs[8] = '{2'd0, 1'b1, 1'b1, 4};
        segs[9] = '{2'd0, 1'b0, 1'b0, 2};

        ma = mdl_reset();
        mb = mdl_reset();
        rst_n = 1'b1;
        run   = 1'b0;
        mask  = 4'd0;
        #2 rst_n = 1'b0;

        // Reset state.
        repeat (3) tick();
        #2 rst_n = 1'b1;
        repeat (2) tick();

        // Full frame with all four indices enabled.
        mask = 4'b1111;
        run  = 1'b1;
        for (int s = 0; s < 10; s++) begin
            for (int j = 0; j < segs[s].n; j++) begin
                tick();
                chk("T1.sel",  32'(sel_a),  32'(segs[s].sel));
                chk("T1.en",   32'(en_a),   32'(segs[s].en));
                chk("T1.fd",   32'(fd_a),   32'((j == 0) && segs[s].fd_first));
                chk("T1.busy", 32'(busy_a), 32'd1);
                chk("T1.B_en_continuous", 32'(en_b), 32'd1);
            end
        end

        // Alternating indices, then a single enabled index.
        mask = 4'b1010;
        repeat (30) tick();
        mask = 4'b0100;
        repeat (20) tick();

        // Run dropped on the second ON cycle at sel=2, then restart.
        run = 1'b0;
        repeat (2) tick();
        mask = 4'b1110;
        run  = 1'b1;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (sel_a == 2'd2 && en_a) ok = 1;
        end
        chk("T4.reach_sel2", 32'(ok), 32'd1);
        tick();
        run = 1'b0;
        tick();
        chk("T4.en",   32'(en_a),   32'd0);
        chk("T4.busy", 32'(busy_a), 32'd0);
        chk("T4.sel",  32'(sel_a),  32'd2);
        chk("T4.fd",   32'(fd_a),   32'd0);
        run = 1'b1;
        tick();
        chk("T4.restart_sel", 32'(sel_a), 32'd1);
        chk("T4.restart_en",  32'(en_a),  32'd1);

        // Mask cleared during ON at sel=1: dwell and blank complete, then idle.
        mask = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("T5.on_en", 32'(en_a), 32'd1);
            chk("T5.on_sel", 32'(sel_a), 32'd1);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("T5.blank_en", 32'(en_a), 32'd0);
            chk("T5.blank_busy", 32'(busy_a), 32'd1);
        end
        tick();
        chk("T5.idle_busy", 32'(busy_a), 32'd0);
        chk("T5.idle_fd",   32'(fd_a),   32'd0);
        repeat (3) tick();

        // Asynchronous reset between edges while A is blanking on a nonzero sel.
        mask = 4'b1111;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (busy_a && !en_a && sel_a != 2'd0) ok = 1;
        end
        chk("T6.reach_blank", 32'(ok), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("T6.sel",  32'(sel_a),  32'd0);
        chk("T6.en",   32'(en_a),   32'd0);
        chk("T6.fd",   32'(fd_a),   32'd0);
        chk("T6.busy", 32'(busy_a), 32'd0);
        chk("T6.B_busy", 32'(busy_b), 32'd0);
        ma = mdl_reset();
        mb = mdl_reset();
        run = 1'b0;
        repeat (2) tick();
        #2 rst_n = 1'b1;
        repeat (4) tick();
        mask = 4'b0000;
        run  = 1'b1;
        repeat (4) tick();
        chk("T6.idle_no_mask", 32'(busy_a), 32'd0);
        mask = 4'b1001;
        repeat (3) tick();

        // Randomized run/mask activity.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) run = ~run;
            if ($urandom_range(0, 9) == 0)  mask = 4'($urandom_range(0, 15));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_decoder_scan_ctrl

`default_nettype wire
